// File: rtl/clk_div_meas.sv
// Recovers the divisor of a toggling divided clock by timing its half-period
// in fast-clock cycles, and reports lock once the reading is stable.
module clk_div_meas #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  output logic [CNT_W-1:0] div_base,
  output logic             meas_stb,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK = 4'(LOCK_CNT);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             match;

  logic       tog;
  logic       cnt_max;
  logic       same;
  logic [3:0] match_inc;

  assign tog       = sync[SYNC_STAGES-1] ^ prev;
  assign cnt_max   = &cnt;
  assign same      = (cnt == div_base);
  assign match_inc = (match == LOCK) ? match : match + 4'd1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], div_clk};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tog) begin
      cnt <= '0;
    end else if (!cnt_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      match    <= '0;
      div_base <= '0;
      meas_stb <= 1'b0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      meas_stb <= 1'b0;
      if (tog) begin
        timeout <= 1'b0;
        unique case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            div_base <= cnt;
            meas_stb <= 1'b1;
            valid    <= 1'b1;
            match    <= 4'd1;
            state    <= TRACK;
          end
          TRACK: begin
            meas_stb <= 1'b1;
            if (same) begin
              match <= match_inc;
              if (match_inc == LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              div_base <= cnt;
              match    <= 4'd1;
            end
          end
          LOCKED: begin
            meas_stb <= 1'b1;
            if (!same) begin
              div_base <= cnt;
              match    <= 4'd1;
              locked   <= 1'b0;
              state    <= TRACK;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && cnt_max) begin
        // Lost clock: drop back to hunting, keep last reading visible
        timeout <= 1'b1;
        valid   <= 1'b0;
        locked  <= 1'b0;
        match   <= '0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meas.sv
// Bench for clk_div_meas: interval-level reference model checked every
// cycle, plus table and hand-written boundary sequences.
module tb_clk_div_meas;

  localparam int LOCK = 4;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       div_clk = 1'b0;
  logic [7:0] div_base;
  logic       meas_stb;
  logic       valid;
  logic       locked;
  logic       timeout;

  always #5 clk_in = ~clk_in;

  clk_div_meas dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div_clk (div_clk),
    .div_base(div_base),
    .meas_stb(meas_stb),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  typedef struct {
    int   h;
    int   len;
    int   base;
    logic lk;
    logic vl;
    logic to;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 10;
  bit hist[0:65535];
  int h = 0;
  int tcnt = 0;

  // Model: mode 0 = hunting, 1 = one edge seen, 2 = measuring
  int m_mode = 0;
  int m_last = 0;
  int m_run = 0;
  int m_base = 0;
  bit m_stb = 0;
  bit m_valid = 0;
  bit m_to = 0;

  task automatic model_step();
    bit e;
    int cv;
    e = hist[cyc-3] ^ hist[cyc-4];
    cv = cyc - m_last - 1;
    if (cv > 255) cv = 255;
    m_stb = 0;
    if (e) begin
      m_to = 0;
      if (m_mode != 0) begin
        m_stb = 1;
        m_valid = 1;
        if (m_mode == 2 && cv == m_base) begin
          if (m_run < LOCK) m_run++;
        end else begin
          m_run = 1;
        end
        m_base = cv;
        m_mode = 2;
      end else begin
        m_mode = 1;
      end
      m_last = cyc;
    end else if (m_mode != 0 && cv == 255) begin
      m_to = 1;
      m_valid = 0;
      m_run = 0;
      m_mode = 0;
    end
  endtask

  task automatic check_model();
    bit m_lk;
    m_lk = (m_run >= LOCK);
    tests++;
    if (div_base !== 8'(m_base) || meas_stb !== m_stb ||
        valid !== m_valid || locked !== m_lk || timeout !== m_to) begin
      fails++;
      $display("FAIL model cyc=%0d got base=%0d stb=%b vld=%b lk=%b to=%b exp base=%0d stb=%b vld=%b lk=%b to=%b",
               cyc, div_base, meas_stb, valid, locked, timeout,
               m_base, m_stb, m_valid, m_lk, m_to);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic drive();
    if (h > 0) begin
      tcnt++;
      if (tcnt >= h) begin
        div_clk = ~div_clk;
        tcnt = 0;
      end
    end
    hist[cyc] = div_clk;
  endtask

  task automatic step();
    @(posedge clk_in);
    cyc++;
    #1;
    model_step();
    check_model();
    drive();
  endtask

  task automatic run(input int hh, input int len);
    if (hh != h) tcnt = 0;
    h = hh;
    repeat (len) step();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_in);
    #($urandom_range(0, 3));
    rst = 1'b1;
    #1;
    chk("rst_async", {div_base, meas_stb, valid, locked, timeout}, 0);
    repeat (n) begin
      @(posedge clk_in);
      cyc++;
      #1;
      chk("rst_hold", {div_base, meas_stb, valid, locked, timeout}, 0);
      drive();
    end
    @(negedge clk_in);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) hist[cyc-i] = 0;
    m_last = cyc;
    m_mode = 0;
    m_run = 0;
    m_base = 0;
    m_stb = 0;
    m_valid = 0;
    m_to = 0;
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{10, 100, 9, 1, 1, 0};
    vt[1] = '{4, 60, 3, 1, 1, 0};
    vt[2] = '{1, 30, 0, 1, 1, 0};
    vt[3] = '{0, 300, 0, 0, 0, 1};
    vt[4] = '{256, 1792, 255, 1, 1, 0};
    vt[5] = '{257, 771, 255, 0, 0, 0};
    vt[6] = '{10, 100, 9, 1, 1, 0};
    vt[7] = '{4, 40, 3, 1, 1, 0};

    do_reset(3);

    foreach (vt[i]) begin
      run(vt[i].h, vt[i].len);
      chk($sformatf("tbl%0d_base", i), div_base, vt[i].base);
      chk($sformatf("tbl%0d_lock", i), locked, vt[i].lk);
      chk($sformatf("tbl%0d_valid", i), valid, vt[i].vl);
      chk($sformatf("tbl%0d_tmo", i), timeout, vt[i].to);
    end

    // Locked at 9, divider steps to 3
    run(10, 100);
    chk("pre_sw_lock", locked, 1);
    run(4, 4);
    run(4, 3);
    chk("sw_base", div_base, 3);
    chk("sw_unlock", locked, 0);
    chk("sw_stb", meas_stb, 1);
    run(4, 1);
    run(4, 8);
    run(4, 2);
    chk("relock_early", locked, 0);
    run(4, 1);
    chk("relock", locked, 1);

    // Exact timeout boundary and restart
    run(10, 100);
    run(0, 258);
    chk("tmo_before", timeout, 0);
    chk("tmo_before_lk", locked, 1);
    run(0, 1);
    chk("tmo_at", timeout, 1);
    chk("tmo_valid", valid, 0);
    chk("tmo_lock", locked, 0);
    chk("tmo_base", div_base, 9);
    run(10, 10);
    run(10, 3);
    chk("rs1_tmo", timeout, 0);
    chk("rs1_valid", valid, 0);
    chk("rs1_stb", meas_stb, 0);
    run(10, 7);
    run(10, 3);
    chk("rs2_stb", meas_stb, 1);
    chk("rs2_valid", valid, 1);
    chk("rs2_base", div_base, 9);

    // Reset mid-lock at an arbitrary phase
    run(7, 70);
    chk("pre_rst_lock", locked, 1);
    run(7, $urandom_range(0, 6));
    do_reset(1);
    run(7, 70);
    chk("post_rst_base", div_base, 6);
    chk("post_rst_lock", locked, 1);

    for (int s = 0; s < 30; s++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) run(0, $urandom_range(200, 320));
      else if (r == 1) run($urandom_range(250, 260), 600);
      else if (r == 2) do_reset(1);
      else run($urandom_range(1, 12), $urandom_range(10, 120));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_meas.md
Name: clk_div_meas

Overview:
- Measures the half-period of a divided toggle clock produced by the team's programmable clock dividers. The result is expressed as the divider setting that would produce it: half-period of N cycles reads back as N-1.
- Runs on the same fast source clock as the divider. The divided clock is treated as asynchronous.
- Used for self-check of the LCM/pattern clock path: the loop compares the recovered divisor against the programmed div_base and flags loss of clock.

Parameters:
- CNT_W, 8: width of the elapsed-cycle counter and of div_base. Maximum reportable div_base is 2^CNT_W-1.
- LOCK_CNT, 4: number of consecutive identical measurements required to assert locked (range 2..15).
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer (minimum 2).

Ports:
- clk_in  input  1  fast source clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- div_clk  input  1  divided clock under test, asynchronous.
- div_base  output  CNT_W  last measured half-period minus 1.
- meas_stb  output  1  one-cycle pulse when div_base is updated.
- valid  output  1  div_base holds a real measurement.
- locked  output  1  LOCK_CNT consecutive equal measurements seen.
- timeout  output  1  no div_clk edge for 2^CNT_W cycles; sticky until the next edge.

Behaviour:
- Interface: one clock (clk_in); reset is asynchronous and active-high (rst).
- Reset values: div_base=0, meas_stb=0, valid=0, locked=0, timeout=0. Counter=0, match count=0, state=IDLE, synchronizer and prev flops=0.
- Synchronizer: div_clk passes through SYNC_STAGES flops; prev holds the last synced value.
- edge = synced XOR prev. Both rising and falling edges count.
- Elapsed counter cnt (CNT_W bits):
  - On an edge cycle, cnt <= 0.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - Consequence: edges N cycles apart leave cnt = N-1 on the second edge cycle.
- States and transitions:
  - IDLE (no edge seen since reset or timeout). On edge -> ARM. Nothing is captured.
  - ARM (one edge seen; the first interval is incomplete or unknown). On edge -> TRACK. Capture div_base <= cnt, pulse meas_stb, set valid=1, match=1.
  - TRACK.
    - On edge with cnt == div_base: match <= match+1, pulse meas_stb. If match+1 == LOCK_CNT -> LOCKED and locked=1.
    - On edge with cnt != div_base: div_base <= cnt, match <= 1, pulse meas_stb, stay in TRACK.
  - LOCKED.
    - On edge with cnt == div_base: pulse meas_stb, stay.
    - On edge with mismatch: div_base <= cnt, match <= 1, locked <= 0, -> TRACK, pulse meas_stb.
- Output timing: all outputs are registered. They update on the clock edge that ends the edge-detect cycle, so the response lags a div_clk transition by SYNC_STAGES+1 clk_in cycles.
- Timeout:
  - In any state except IDLE, a cycle with cnt == all-ones and no edge triggers it.
  - Effect: timeout <= 1, valid <= 0, locked <= 0, match <= 0, -> IDLE. div_base holds its last value.
  - timeout clears on the next edge, which also moves IDLE -> ARM.
- Timeout boundary: an edge on a cycle where cnt == all-ones is a valid measurement with div_base = 2^CNT_W-1, and no timeout occurs.
- Fastest input: div_clk toggling every clk_in cycle gives cnt=0 at each edge, so div_base=0. Anything faster is undefined (aliasing).
- match counter saturates at LOCK_CNT and never wraps.
- Asynchronous reset mid-measurement returns everything to reset values immediately. The first post-reset edge is always discarded, via ARM.

Test Plan:
- Divider model with div_base=9 (toggle every 10 cycles), CNT_W=8 -> valid and meas_stb on the 2nd synced edge with div_base=9. locked=1 on the 5th edge (4 equal measurements). meas_stb every 10 cycles.
- div_base=0 model (toggle every cycle) -> div_base=0, locked after 5 edges, meas_stb high continuously once in TRACK.
- Locked at 9, divider switches to 3 -> first short interval: div_base=3 and locked=0 the same cycle. Re-lock after 3 more equal edges (4 in a row).
- Stop div_clk while locked -> exactly 255 cycles after the last edge's cnt reset, timeout=1, valid=0, locked=0. Restart -> timeout=0 on the 1st edge, valid on the 2nd.
- Edges exactly 256 cycles apart (cnt reaches 255 on the edge cycle) -> div_base=255, no timeout. Edges 257 apart -> timeout asserts.
- Assert rst for 1 cycle mid-LOCKED at arbitrary phase -> all outputs 0 that cycle. After release, the first edge gives no meas_stb; the second gives a correct div_base.
